// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end: NOP encoding,
// fetch FSM states and the sequential PC step.
package inst_fetch_unit_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          PC_INC   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } ifuState_e;

endpackage

// File: rtl/ifu_fifo.sv
// Parameterised synchronous FIFO with synchronous clear, occupancy count and
// full/empty flags; head entry is visible combinationally on headData.
module ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] wrPtr, rdPtr;
    logic             doPush, doPop;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign count    = wrPtr - rdPtr;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign doPop    = pop && !empty;
    assign doPush   = push && (!full || doPop);
    assign headData = mem[rdPtr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (clr) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + CNT_W'(1);
            if (doPop)  rdPtr <= rdPtr + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !clr) mem[wrPtr[PTR_W-1:0]] <= pushData;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front-end: issues sequential requests to a variable-latency memory,
// buffers in-order responses and feeds decode. Define IFU_BYPASS_EN to let a
// response reach decode in its arrival cycle when the buffer is empty.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              FlushIn,
    input  logic [ADDR_W-1:0] FlushAddrIn,
    input  logic              HoldIn,
    output logic              ReqValid,
    output logic [ADDR_W-1:0] ReqAddr,
    input  logic              ReqReady,
    input  logic              RspValid,
    input  logic [INST_W-1:0] RspData,
    output logic              InstValidOut,
    output logic [INST_W-1:0] InstOut,
    output logic [ADDR_W-1:0] InstAddrOut
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } fetchEntry_t;

    ifuState_e         state, nextState;
    logic [ADDR_W-1:0] fetchPc, lastPopAddr, rspAddr;
    logic [CNT_W-1:0]  outstanding, outstandingNext, dropCnt, dropCntNext;
    logic [CNT_W-1:0]  fifoCount, aqCount;
    logic [CNT_W:0]    reserved;
    logic              fifoFull, fifoEmpty, aqFull, aqEmpty;
    logic              reqFire, rspKeep, bypassHit, bypassTake;
    logic              fifoPush, fifoPop;
    fetchEntry_t       pushEntry, headEntry;

    // Every accepted request reserves a buffer slot, so the buffer cannot overflow.
    assign reserved = {1'b0, outstanding} + {1'b0, fifoCount};
    assign ReqValid = (state == FETCH) && (reserved < (CNT_W+1)'(DEPTH)) && !FlushIn;
    assign ReqAddr  = fetchPc;
    assign reqFire  = ReqValid && ReqReady;
    assign rspKeep  = RspValid && (dropCnt == '0);

`ifdef IFU_BYPASS_EN
    assign bypassHit = fifoEmpty && rspKeep;
`else
    assign bypassHit = 1'b0;
`endif

    assign bypassTake = bypassHit && !HoldIn;
    assign fifoPop    = !fifoEmpty && !HoldIn;
    assign fifoPush   = rspKeep && !FlushIn && !bypassTake;
    assign pushEntry  = '{addr: rspAddr, inst: RspData};

    ifu_fifo #(.WIDTH(ADDR_W + INST_W), .DEPTH(DEPTH)) uInstFifo (
        .clk      (Clk),
        .rstN     (Rst),
        .clr      (FlushIn),
        .push     (fifoPush),
        .pushData (pushEntry),
        .pop      (fifoPop),
        .headData (headEntry),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    ifu_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) uAddrQueue (
        .clk      (Clk),
        .rstN     (Rst),
        .clr      (FlushIn),
        .push     (reqFire),
        .pushData (fetchPc),
        .pop      (rspKeep),
        .headData (rspAddr),
        .count    (aqCount),
        .full     (aqFull),
        .empty    (aqEmpty)
    );

    always_comb begin
        InstValidOut = !fifoEmpty || bypassHit;
        InstOut      = INST_W'(NOP_INST);
        InstAddrOut  = lastPopAddr;
        if (!fifoEmpty) begin
            InstOut     = headEntry.inst;
            InstAddrOut = headEntry.addr;
        end else if (bypassHit) begin
            InstOut     = RspData;
            InstAddrOut = rspAddr;
        end
    end

    always_comb begin
        outstandingNext = outstanding;
        if (reqFire)  outstandingNext = outstandingNext + CNT_W'(1);
        if (RspValid) outstandingNext = outstandingNext - CNT_W'(1);

        dropCntNext = dropCnt;
        if (RspValid && dropCnt != '0) dropCntNext = dropCnt - CNT_W'(1);
        // A response landing with the flush is already excluded from outstandingNext.
        if (FlushIn) dropCntNext = outstandingNext;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = FETCH;
            FETCH:   nextState = FETCH;
            DRAIN:   if (dropCntNext == '0) nextState = FETCH;
            default: nextState = IDLE;
        endcase
        if (FlushIn) nextState = (dropCntNext != '0) ? DRAIN : FETCH;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            fetchPc     <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
            lastPopAddr <= '0;
        end else begin
            state       <= nextState;
            outstanding <= outstandingNext;
            dropCnt     <= dropCntNext;
            if (FlushIn)      fetchPc <= FlushAddrIn;
            else if (reqFire) fetchPc <= fetchPc + ADDR_W'(PC_INC);
            if (fifoPop)         lastPopAddr <= headEntry.addr;
            else if (bypassTake) lastPopAddr <= rspAddr;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge Clk) begin
        if (Rst) begin
            assert (!(fifoPush && fifoFull && !fifoPop && !FlushIn));
            assert (!(reqFire && aqFull));
            assert (!(rspKeep && aqEmpty));
            assert ((dropCnt != '0) || (aqCount == outstanding));
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: startup vector table, directed corner sequences
// and randomized traffic against a queue-based model of fetch behaviour.
module tb_inst_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0, Rst = 1'b0;
    logic        FlushIn = 1'b0, HoldIn = 1'b0, ReqReady = 1'b0, RspValid = 1'b0;
    logic [63:0] FlushAddrIn = '0;
    logic [31:0] RspData = '0;
    logic        ReqValid, InstValidOut;
    logic [63:0] ReqAddr, InstAddrOut;
    logic [31:0] InstOut;

    inst_fetch_unit dut (
        .Clk(Clk), .Rst(Rst), .FlushIn(FlushIn), .FlushAddrIn(FlushAddrIn),
        .HoldIn(HoldIn), .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqReady(ReqReady),
        .RspValid(RspValid), .RspData(RspData), .InstValidOut(InstValidOut),
        .InstOut(InstOut), .InstAddrOut(InstAddrOut)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic [63:0] addr; logic [31:0] inst; } ent_t;
    typedef struct { logic [63:0] addr; int due; } memReq_t;
    typedef struct {
        logic hold; logic rdy;
        logic expRv; logic [63:0] expRa;
        logic expIv; logic [63:0] expIa; logic [31:0] expI;
    } vec_t;

    int errors = 0, checks = 0;
    int cyc = 0, lat = 1, lastDue = 0;

    // Model state: fetch PC, decode buffer, addresses awaiting data,
    // outstanding/discard counts and phase (0 idle, 1 fetching, 2 discarding).
    logic [63:0] mPc, mLast;
    ent_t        mFifo[$];
    logic [63:0] mInq[$];
    int          mOut, mDrop, mPhase;
    memReq_t     memQ[$];

    function automatic logic [31:0] instOf(input logic [63:0] a);
        return ~a[31:0] ^ 32'h1234_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        mPc = RST_PC; mLast = '0; mFifo.delete(); mInq.delete();
        mOut = 0; mDrop = 0; mPhase = 0; memQ.delete(); lastDue = 0;
    endtask

    task automatic checkReset();
        check("rst.ReqValid", 64'(ReqValid), 64'd0);
        check("rst.ReqAddr", ReqAddr, RST_PC);
        check("rst.InstValid", 64'(InstValidOut), 64'd0);
        check("rst.InstOut", 64'(InstOut), 64'(NOP));
        check("rst.InstAddr", InstAddrOut, 64'd0);
    endtask

    // Called at a negedge with HoldIn/ReqReady/FlushIn set: drives memory,
    // compares outputs against the model, then advances the model one edge.
    task automatic evalCycle();
        logic byp, expRv, expIv, acc, bTake;
        logic [63:0] rspAddr, expIa, a;
        logic [31:0] expI;
        RspValid = 1'b0;
        RspData  = '0;
        if (memQ.size() > 0) begin
            if (memQ[0].due <= cyc) begin
                RspValid = 1'b1;
                RspData  = instOf(memQ[0].addr);
            end
        end
        #1;
        byp = 1'b0;
`ifdef IFU_BYPASS_EN
        byp = (mFifo.size() == 0) && (mDrop == 0) && RspValid;
`endif
        rspAddr = (mInq.size() > 0) ? mInq[0] : 64'd0;
        expIv = (mFifo.size() > 0) || byp;
        expI  = (mFifo.size() > 0) ? mFifo[0].inst : (byp ? instOf(rspAddr) : NOP);
        expIa = (mFifo.size() > 0) ? mFifo[0].addr : (byp ? rspAddr : mLast);
        expRv = (mPhase == 1) && (mOut + mFifo.size() < DEPTH) && !FlushIn;
        check("ReqValid", 64'(ReqValid), 64'(expRv));
        check("ReqAddr", ReqAddr, mPc);
        check("InstValidOut", 64'(InstValidOut), 64'(expIv));
        check("InstOut", 64'(InstOut), 64'(expI));
        check("InstAddrOut", InstAddrOut, expIa);

        acc   = expRv && ReqReady;
        bTake = byp && !HoldIn;
        if (mFifo.size() > 0 && !HoldIn) begin
            mLast = mFifo[0].addr;
            void'(mFifo.pop_front());
        end else if (bTake) begin
            mLast = rspAddr;
        end
        if (RspValid) begin
            void'(memQ.pop_front());
            mOut--;
            if (mDrop > 0) mDrop--;
            else begin
                a = mInq.pop_front();
                if (!FlushIn && !bTake) mFifo.push_back('{a, instOf(a)});
            end
        end
        if (acc) begin
            memReq_t r;
            r.addr = mPc;
            r.due  = (cyc + lat > lastDue) ? cyc + lat : lastDue + 1;
            lastDue = r.due;
            memQ.push_back(r);
            mInq.push_back(mPc);
            mPc += 64'd4;
            mOut++;
        end
        if (FlushIn) begin
            mFifo.delete(); mInq.delete();
            mPc = FlushAddrIn; mDrop = mOut;
            mPhase = (mDrop != 0) ? 2 : 1;
        end else if (mPhase == 0) mPhase = 1;
        else if (mPhase == 2 && mDrop == 0) mPhase = 1;
        cyc++;
    endtask

    task automatic cycle();
        evalCycle();
        @(negedge Clk);
    endtask

    task automatic doReset();
        Rst = 1'b0; FlushIn = 1'b0; HoldIn = 1'b0; ReqReady = 1'b0; RspValid = 1'b0;
        modelReset();
        repeat (2) @(negedge Clk);
        checkReset();
        Rst = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        logic found;
        logic [63:0] stallAddr;

        vecs[0] = '{0, 1, 0, RST_PC,        0, 64'd0,       NOP};
        vecs[1] = '{0, 1, 1, RST_PC,        0, 64'd0,       NOP};
        vecs[2] = '{0, 1, 1, RST_PC + 4,    0, 64'd0,       NOP};
        vecs[3] = '{0, 1, 1, RST_PC + 8,    1, RST_PC,      instOf(RST_PC)};
        vecs[4] = '{0, 1, 1, RST_PC + 12,   1, RST_PC + 4,  instOf(RST_PC + 4)};
        vecs[5] = '{0, 1, 1, RST_PC + 16,   1, RST_PC + 8,  instOf(RST_PC + 8)};
`ifdef IFU_BYPASS_EN
        vecs[2] = '{0, 1, 1, RST_PC + 4,    1, RST_PC,      instOf(RST_PC)};
        vecs[3] = '{0, 1, 1, RST_PC + 8,    1, RST_PC + 4,  instOf(RST_PC + 4)};
        vecs[4] = '{0, 1, 1, RST_PC + 12,   1, RST_PC + 8,  instOf(RST_PC + 8)};
        vecs[5] = '{0, 1, 1, RST_PC + 16,   1, RST_PC + 12, instOf(RST_PC + 12)};
`endif

        // Startup with 1-cycle memory
        @(negedge Clk);
        doReset();
        lat = 1;
        for (int i = 0; i < 6; i++) begin
            HoldIn = vecs[i].hold; ReqReady = vecs[i].rdy;
            evalCycle();
            check("tbl.ReqValid", 64'(ReqValid), 64'(vecs[i].expRv));
            check("tbl.ReqAddr", ReqAddr, vecs[i].expRa);
            check("tbl.InstValid", 64'(InstValidOut), 64'(vecs[i].expIv));
            check("tbl.InstAddr", InstAddrOut, vecs[i].expIa);
            check("tbl.InstOut", 64'(InstOut), 64'(vecs[i].expI));
            @(negedge Clk);
        end

        // Decode held from reset: buffer fills to DEPTH, then in-order pops
        doReset();
        HoldIn = 1'b1; ReqReady = 1'b1;
        repeat (10) cycle();
        evalCycle();
        check("hold.ReqValid", 64'(ReqValid), 64'd0);
        check("hold.head", InstAddrOut, RST_PC);
        @(negedge Clk);
        HoldIn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            evalCycle();
            check("hold.popAddr", InstAddrOut, RST_PC + 64'(4 * i));
            check("hold.popValid", 64'(InstValidOut), 64'd1);
            @(negedge Clk);
        end

        // Memory not ready for 3 cycles: request held stable, accepted once
        repeat (3) cycle();
        stallAddr = mPc;
        ReqReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            evalCycle();
            check("stall.ReqValid", 64'(ReqValid), 64'd1);
            check("stall.ReqAddr", ReqAddr, stallAddr);
            @(negedge Clk);
        end
        ReqReady = 1'b1;
        cycle();
        evalCycle();
        check("stall.nextAddr", ReqAddr, stallAddr + 64'd4);
        @(negedge Clk);

        // Flush with 3 requests in flight at 4-cycle latency
        lat = 4;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (mOut == 3 && !(memQ.size() > 0 && memQ[0].due <= cyc)) found = 1'b1;
            else cycle();
        end
        check("flush3.found", 64'(found), 64'd1);
        FlushIn = 1'b1; FlushAddrIn = 64'h8000_0100;
        cycle();
        FlushIn = 1'b0;
        evalCycle();
        check("flush3.drainNoReq", 64'(ReqValid), 64'd0);
        check("flush3.empty", 64'(InstValidOut), 64'd0);
        check("flush3.ReqAddr", ReqAddr, 64'h8000_0100);
        @(negedge Clk);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (mFifo.size() > 0) found = 1'b1;
            else cycle();
        end
        check("flush3.gotInst", 64'(found), 64'd1);
        evalCycle();
        check("flush3.firstAddr", InstAddrOut, 64'h8000_0100);
        @(negedge Clk);

        // Flush coinciding with a response, one other request in flight
        lat = 2;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (mOut == 2 && memQ.size() > 0 && memQ[0].due <= cyc) found = 1'b1;
            else cycle();
        end
        check("flushRsp.found", 64'(found), 64'd1);
        FlushIn = 1'b1; FlushAddrIn = 64'h8000_0400;
        cycle();
        FlushIn = 1'b0;
        check("flushRsp.drop", 64'(mDrop), 64'd1);
        evalCycle();
        check("flushRsp.drainNoReq", 64'(ReqValid), 64'd0);
        @(negedge Clk);
        repeat (8) cycle();

        // Asynchronous reset in the middle of a drain
        lat = 5;
        for (int k = 0; k < 40 && mOut < 2; k++) cycle();
        FlushIn = 1'b1; FlushAddrIn = 64'h8000_0200;
        cycle();
        FlushIn = 1'b0;
        cycle();
        #2 Rst = 1'b0;
        #1 checkReset();
        @(negedge Clk);
        doReset();
        lat = 1; ReqReady = 1'b1;
        cycle();
        evalCycle();
        check("rstDrain.restart", ReqAddr, RST_PC);
        check("rstDrain.reqValid", 64'(ReqValid), 64'd1);
        @(negedge Clk);

        // Randomized traffic, including address wrap at the top of memory
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) lat = $urandom_range(1, 5);
            HoldIn   = ($urandom_range(0, 3) == 0);
            ReqReady = ($urandom_range(0, 3) != 0);
            FlushIn  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) FlushAddrIn = 64'hFFFF_FFFF_FFFF_FFF4;
            else FlushAddrIn = {32'h0, $urandom} & ~64'h3;
            cycle();
        end
        FlushIn = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
